// File: rtl/sensor_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_bus_pkg
// Purpose  : Shared types and idle pin levels for the sensor bus arbiter.
//            state_e - arbiter FSM states
//            owner_e - identity of the most recent bus owner
//            *_IDLE  - pin levels driven while nobody owns the bus
// Revision : 1.0 - initial release
// ============================================================================
package sensor_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_I2C = 2'd1,
        OWN_SPI = 2'd2,
        GUARD   = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_I2C = 1'b0,
        OWNER_SPI = 1'b1
    } owner_e;

    localparam logic SCLK_IDLE = 1'b1;
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic OE_IDLE   = 1'b0;

endpackage : sensor_bus_pkg
`default_nettype wire

// File: rtl/sensor_bus_pin_mux.sv
`default_nettype none
// ============================================================================
// Module   : sensor_bus_pin_mux
// Purpose  : Registered, glitch-free pin driver for the shared sensor bus.
//            Routes the current owner's signals to the pins one cycle later;
//            drives the idle levels in IDLE/GUARD and on reset.
// Ports    : clk, reset_n           - clock, synchronous active-low reset
//            state_i                - arbiter state for the coming cycle
//            i2c_scl_i, i2c_sda_oe_i             - I2C master pin requests
//            spi_sclk_i, spi_cs_n_i, spi_sdio_oe_i - SPI master pin requests
//            bus_sclk_o, bus_cs_n_o, bus_sda_oe_o  - registered pin outputs
// Revision : 1.0 - initial release
// ============================================================================
module sensor_bus_pin_mux
    import sensor_bus_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  state_e state_i,
    input  logic   i2c_scl_i,
    input  logic   i2c_sda_oe_i,
    input  logic   spi_sclk_i,
    input  logic   spi_cs_n_i,
    input  logic   spi_sdio_oe_i,
    output logic   bus_sclk_o,
    output logic   bus_cs_n_o,
    output logic   bus_sda_oe_o
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_sclk_o   <= SCLK_IDLE;
            bus_cs_n_o   <= CS_N_IDLE;
            bus_sda_oe_o <= OE_IDLE;
        end else begin
            case (state_i)
                OWN_I2C: begin
                    bus_sclk_o   <= i2c_scl_i;
                    bus_cs_n_o   <= CS_N_IDLE;
                    bus_sda_oe_o <= i2c_sda_oe_i;
                end
                OWN_SPI: begin
                    bus_sclk_o   <= spi_sclk_i;
                    bus_cs_n_o   <= spi_cs_n_i;
                    bus_sda_oe_o <= spi_sdio_oe_i;
                end
                default: begin
                    bus_sclk_o   <= SCLK_IDLE;
                    bus_cs_n_o   <= CS_N_IDLE;
                    bus_sda_oe_o <= OE_IDLE;
                end
            endcase
        end
    end

endmodule : sensor_bus_pin_mux
`default_nettype wire

// File: rtl/sensor_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sensor_bus_arbiter
// Purpose  : Arbitrates the shared I2C_SCLK/I2C_SDAT pin pair between the
//            I2C bit-bang master (requester 0) and the gsensor SPI master
//            (requester 1). Round-robin on ties, idle guard interval on every
//            handover, registered pin outputs.
// Ports    : clk, reset_n                    - clock, sync active-low reset
//            i2c_req/i2c_gnt, spi_req/spi_gnt - request/grant handshakes
//            i2c_scl_in, i2c_sda_oe_in       - I2C master pin requests
//            spi_sclk_in, spi_cs_n_in, spi_sdio_oe_in - SPI master pins
//            bus_sclk, bus_cs_n, bus_sda_oe  - registered bus pins
//            sel_i2c, busy                   - routing select, non-idle flag
//            timeout_flag, timeout_clr       - sticky forced-revoke flag
// Options  : SENSOR_BUS_TIMEOUT_EN - enables the HOLD_MAX ownership limit.
//            Without it timeout_flag is 0 and timeout_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_bus_arbiter
    import sensor_bus_pkg::*;
#(
    parameter int GUARD_CYCLES = 8,
    parameter int HOLD_MAX     = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i2c_req,
    output logic i2c_gnt,
    input  logic i2c_scl_in,
    input  logic i2c_sda_oe_in,
    input  logic spi_req,
    output logic spi_gnt,
    input  logic spi_sclk_in,
    input  logic spi_cs_n_in,
    input  logic spi_sdio_oe_in,
    output logic bus_sclk,
    output logic bus_cs_n,
    output logic bus_sda_oe,
    output logic sel_i2c,
    output logic busy,
    output logic timeout_flag,
    input  logic timeout_clr
);

    localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam int HOLD_W  = $clog2(HOLD_MAX + 1);
    localparam logic [GUARD_W-1:0] c_GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);

    state_e              state_q, state_d;
    owner_e              last_owner_q, last_owner_d;
    logic [GUARD_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic                w_hold_expired;
    logic                w_revoke;

`ifdef SENSOR_BUS_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              timeout_flag_q;

    assign w_hold_expired = (hold_cnt_q == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt_q     <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            // Zero outside ownership so every OWN_* entry starts from 0.
            if (state_q == OWN_I2C || state_q == OWN_SPI)
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            else
                hold_cnt_q <= '0;
            // Set has priority over clear.
            if (w_revoke)
                timeout_flag_q <= 1'b1;
            else if (timeout_clr)
                timeout_flag_q <= 1'b0;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    logic w_unused_tmo;

    assign w_hold_expired = 1'b0;
    assign timeout_flag   = 1'b0;
    assign w_unused_tmo   = timeout_clr ^ w_revoke ^ (HOLD_W == 0);
`endif

    // Next-state decode. Every exit from ownership passes through GUARD;
    // a revoke is an exit while the owner still holds its request.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        guard_cnt_d  = guard_cnt_q;
        w_revoke     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i2c_req && spi_req)
                    state_d = (last_owner_q == OWNER_I2C) ? OWN_SPI : OWN_I2C;
                else if (i2c_req)
                    state_d = OWN_I2C;
                else if (spi_req)
                    state_d = OWN_SPI;
            end
            OWN_I2C: begin
                if (!i2c_req || w_hold_expired) begin
                    w_revoke     = i2c_req;
                    state_d      = GUARD;
                    last_owner_d = OWNER_I2C;
                    guard_cnt_d  = c_GUARD_LOAD;
                end
            end
            OWN_SPI: begin
                if (!spi_req || w_hold_expired) begin
                    w_revoke     = spi_req;
                    state_d      = GUARD;
                    last_owner_d = OWNER_SPI;
                    guard_cnt_d  = c_GUARD_LOAD;
                end
            end
            GUARD: begin
                if (guard_cnt_q == '0)
                    state_d = IDLE;
                else
                    guard_cnt_d = guard_cnt_q - GUARD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State plus registered outputs, all decoded from the next state so
    // grants and pin routing change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_SPI;
            guard_cnt_q  <= '0;
            i2c_gnt      <= 1'b0;
            spi_gnt      <= 1'b0;
            sel_i2c      <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            guard_cnt_q  <= guard_cnt_d;
            i2c_gnt      <= (state_d == OWN_I2C);
            spi_gnt      <= (state_d == OWN_SPI);
            sel_i2c      <= (state_d != OWN_SPI);
            busy         <= (state_d != IDLE);
        end
    end

    sensor_bus_pin_mux u_pin_mux (
        .clk           (clk),
        .reset_n       (reset_n),
        .state_i       (state_d),
        .i2c_scl_i     (i2c_scl_in),
        .i2c_sda_oe_i  (i2c_sda_oe_in),
        .spi_sclk_i    (spi_sclk_in),
        .spi_cs_n_i    (spi_cs_n_in),
        .spi_sdio_oe_i (spi_sdio_oe_in),
        .bus_sclk_o    (bus_sclk),
        .bus_cs_n_o    (bus_cs_n),
        .bus_sda_oe_o  (bus_sda_oe)
    );

endmodule : sensor_bus_arbiter
`default_nettype wire

// File: tb/tb_sensor_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_bus_arbiter
// Purpose  : Directed self-checking bench for sensor_bus_arbiter
//            (GUARD_CYCLES=8, HOLD_MAX=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_bus_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic i2c_req = 1'b0, i2c_scl_in = 1'b1, i2c_sda_oe_in = 1'b0;
    logic spi_req = 1'b0, spi_sclk_in = 1'b1, spi_cs_n_in = 1'b1, spi_sdio_oe_in = 1'b0;
    logic timeout_clr = 1'b0;
    logic i2c_gnt, spi_gnt, bus_sclk, bus_cs_n, bus_sda_oe, sel_i2c, busy, timeout_flag;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sensor_bus_arbiter #(.GUARD_CYCLES(8), .HOLD_MAX(100)) dut (
        .clk(clk), .reset_n(reset_n),
        .i2c_req(i2c_req), .i2c_gnt(i2c_gnt),
        .i2c_scl_in(i2c_scl_in), .i2c_sda_oe_in(i2c_sda_oe_in),
        .spi_req(spi_req), .spi_gnt(spi_gnt),
        .spi_sclk_in(spi_sclk_in), .spi_cs_n_in(spi_cs_n_in),
        .spi_sdio_oe_in(spi_sdio_oe_in),
        .bus_sclk(bus_sclk), .bus_cs_n(bus_cs_n), .bus_sda_oe(bus_sda_oe),
        .sel_i2c(sel_i2c), .busy(busy),
        .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    // Advance n rising edges; inputs are driven and outputs sampled 1 time
    // unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i2c_req = 1'b0; spi_req = 1'b0; timeout_clr = 1'b0;
        i2c_scl_in = 1'b1; i2c_sda_oe_in = 1'b0;
        spi_sclk_in = 1'b1; spi_cs_n_in = 1'b1; spi_sdio_oe_in = 1'b0;
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({i2c_gnt, spi_gnt, busy, sel_i2c, timeout_flag} !== 5'b00010) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got gnt/gnt/busy/sel/flag=%b expected 00010",
                     {i2c_gnt, spi_gnt, busy, sel_i2c, timeout_flag});
        end
        tests_run++;
        if ({bus_sclk, bus_cs_n, bus_sda_oe} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_pins: got sclk/cs_n/oe=%b expected 110",
                     {bus_sclk, bus_cs_n, bus_sda_oe});
        end
        step(2);
        tests_run++;
        if ({i2c_gnt, spi_gnt, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL idle_no_req: got gnt/gnt/busy=%b expected 000",
                     {i2c_gnt, spi_gnt, busy});
        end
    endtask

    task automatic test_i2c_grant();
        apply_reset();
        step(3);
        i2c_req = 1'b1; i2c_scl_in = 1'b0; i2c_sda_oe_in = 1'b1;
        spi_cs_n_in = 1'b0; spi_sclk_in = 1'b1;
        step(1);
        tests_run++;
        if ({i2c_gnt, spi_gnt, busy, sel_i2c} !== 4'b1011) begin
            tests_failed++;
            $display("FAIL i2c_grant: got gnt/gnt/busy/sel=%b expected 1011",
                     {i2c_gnt, spi_gnt, busy, sel_i2c});
        end
        tests_run++;
        if ({bus_sclk, bus_cs_n, bus_sda_oe} !== 3'b011) begin
            tests_failed++;
            $display("FAIL i2c_pins: got sclk/cs_n/oe=%b expected 011",
                     {bus_sclk, bus_cs_n, bus_sda_oe});
        end
        i2c_scl_in = 1'b1; i2c_sda_oe_in = 1'b0;
        #2;
        tests_run++;
        if ({bus_sclk, bus_sda_oe} !== 2'b01) begin
            tests_failed++;
            $display("FAIL i2c_lag: got sclk/oe=%b expected 01 before edge",
                     {bus_sclk, bus_sda_oe});
        end
        step(1);
        tests_run++;
        if ({bus_sclk, bus_cs_n, bus_sda_oe} !== 3'b110) begin
            tests_failed++;
            $display("FAIL i2c_follow: got sclk/cs_n/oe=%b expected 110",
                     {bus_sclk, bus_cs_n, bus_sda_oe});
        end
        i2c_req = 1'b0;
        step(8);
        tests_run++;
        if ({i2c_gnt, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL guard_busy: got gnt/busy=%b expected 01", {i2c_gnt, busy});
        end
        step(1);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL guard_to_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_tie_and_guard();
        int errs;
        apply_reset();
        step(2);
        i2c_req = 1'b1; spi_req = 1'b1;
        spi_sclk_in = 1'b0; spi_cs_n_in = 1'b0; spi_sdio_oe_in = 1'b1;
        i2c_scl_in = 1'b0; i2c_sda_oe_in = 1'b1;
        step(1);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL tie_first: got i2c/spi gnt=%b expected 10", {i2c_gnt, spi_gnt});
        end
        step(5);
        i2c_req = 1'b0;
        errs = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            if ({i2c_gnt, spi_gnt, bus_sclk, bus_cs_n, bus_sda_oe, sel_i2c} !== 6'b001101)
                errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL guard_idle_pins: got %0d bad cycles expected 0", errs);
        end
        step(1);
        tests_run++;
        if ({i2c_gnt, spi_gnt, sel_i2c} !== 3'b010) begin
            tests_failed++;
            $display("FAIL spi_after_guard: got i2c/spi/sel=%b expected 010",
                     {i2c_gnt, spi_gnt, sel_i2c});
        end
        tests_run++;
        if ({bus_sclk, bus_cs_n, bus_sda_oe} !== 3'b001) begin
            tests_failed++;
            $display("FAIL spi_pins: got sclk/cs_n/oe=%b expected 001",
                     {bus_sclk, bus_cs_n, bus_sda_oe});
        end
    endtask

    // Runs with SPI owning the bus (left over from test_tie_and_guard).
    task automatic test_non_owner_ignored();
        logic [2:0] spi_v [4];
        logic [1:0] i2c_v [4];
        int errs;
        spi_v[0] = 3'b101; spi_v[1] = 3'b010; spi_v[2] = 3'b111; spi_v[3] = 3'b000;
        i2c_v[0] = 2'b01;  i2c_v[1] = 2'b10;  i2c_v[2] = 2'b00;  i2c_v[3] = 2'b11;
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            {spi_sclk_in, spi_cs_n_in, spi_sdio_oe_in} = spi_v[k];
            {i2c_scl_in, i2c_sda_oe_in} = i2c_v[k];
            step(1);
            if ({bus_sclk, bus_cs_n, bus_sda_oe} !== spi_v[k]) begin
                errs++;
                $display("FAIL spi_track_%0d: got %b expected %b", k,
                         {bus_sclk, bus_cs_n, bus_sda_oe}, spi_v[k]);
            end
        end
        tests_run++;
        if (errs != 0) tests_failed++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        spi_req = 1'b1; spi_cs_n_in = 1'b0; spi_sclk_in = 1'b0;
        step(2);
        tests_run++;
        if ({spi_gnt, bus_cs_n} !== 2'b10) begin
            tests_failed++;
            $display("FAIL mid_pre: got spi_gnt/cs_n=%b expected 10", {spi_gnt, bus_cs_n});
        end
        reset_n = 1'b0;
        step(1);
        tests_run++;
        if ({spi_gnt, busy, sel_i2c, bus_sclk, bus_cs_n, bus_sda_oe} !== 6'b001110) begin
            tests_failed++;
            $display("FAIL mid_reset: got gnt/busy/sel/sclk/cs_n/oe=%b expected 001110",
                     {spi_gnt, busy, sel_i2c, bus_sclk, bus_cs_n, bus_sda_oe});
        end
        spi_req = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        spi_req = 1'b1;
        step(1);
        i2c_req = 1'b1;
        step(2);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_spi_owns: got i2c/spi=%b expected 01", {i2c_gnt, spi_gnt});
        end
        spi_req = 1'b0;
        step(1);
        spi_req = 1'b1;
        step(8);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_guard: got i2c/spi=%b expected 00", {i2c_gnt, spi_gnt});
        end
        step(1);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_rr_i2c: got i2c/spi=%b expected 10", {i2c_gnt, spi_gnt});
        end
        step(3);
        i2c_req = 1'b0;
        step(9);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_guard2: got i2c/spi=%b expected 00", {i2c_gnt, spi_gnt});
        end
        step(1);
        tests_run++;
        if ({i2c_gnt, spi_gnt} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_spi_back: got i2c/spi=%b expected 01", {i2c_gnt, spi_gnt});
        end
        spi_req = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        i2c_req = 1'b1;
        step(1);
`ifdef SENSOR_BUS_TIMEOUT_EN
        step(99);
        tests_run++;
        if ({i2c_gnt, timeout_flag} !== 2'b10) begin
            tests_failed++;
            $display("FAIL tmo_before: got gnt/flag=%b expected 10", {i2c_gnt, timeout_flag});
        end
        step(1);
        tests_run++;
        if ({i2c_gnt, busy, timeout_flag} !== 3'b011) begin
            tests_failed++;
            $display("FAIL tmo_revoke: got gnt/busy/flag=%b expected 011",
                     {i2c_gnt, busy, timeout_flag});
        end
        step(3);
        tests_run++;
        if (timeout_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_sticky: got flag=%b expected 1", timeout_flag);
        end
        timeout_clr = 1'b1;
        step(1);
        timeout_clr = 1'b0;
        tests_run++;
        if (timeout_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_clear: got flag=%b expected 0", timeout_flag);
        end
`else
        timeout_clr = 1'b1;
        step(150);
        timeout_clr = 1'b0;
        tests_run++;
        if ({i2c_gnt, timeout_flag} !== 2'b10) begin
            tests_failed++;
            $display("FAIL no_timeout: got gnt/flag=%b expected 10", {i2c_gnt, timeout_flag});
        end
`endif
        i2c_req = 1'b0;
        step(1);
    endtask

    initial begin
        test_reset();
        test_i2c_grant();
        test_tie_and_guard();
        test_non_owner_ignored();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sensor_bus_arbiter
`default_nettype wire

// File: doc/sensor_bus_arbiter.md
Name: sensor_bus_arbiter

Overview:
- Arbitrates the shared accelerometer/EEPROM pin pair (I2C_SCLK clock pin, I2C_SDAT data pin) between two requesters:
  - requester 0: the I2C bit-bang master (scl/sda PIO).
  - requester 1: the gsensor SPI master.
- Replaces the free-running select-PIO clock mux.
- Grants exclusive ownership and enforces an idle guard interval on every handover.
- Drives registered, glitch-free bus pins. Sits between the SOPC masters and the top-level pins.

Parameters:
- GUARD_CYCLES, 8, idle clk cycles inserted after every release; legal range >=1.
- HOLD_MAX, 1000000, maximum ownership length in clk cycles (20 ms at 50 MHz); used only with the optional feature.

Ports:
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  synchronous active-low reset
- i2c_req  in  1  I2C master requests the bus; held high for the whole transaction
- i2c_gnt  out  1  I2C master owns the bus
- i2c_scl_in  in  1  clock driven by the I2C master
- i2c_sda_oe_in  in  1  I2C master data output-enable
- spi_req  in  1  SPI master requests the bus; held high for the whole transaction
- spi_gnt  out  1  SPI master owns the bus
- spi_sclk_in  in  1  clock driven by the SPI master
- spi_cs_n_in  in  1  chip select from the SPI master
- spi_sdio_oe_in  in  1  SPI master data output-enable
- bus_sclk  out  1  to the I2C_SCLK pin
- bus_cs_n  out  1  to the G_SENSOR_CS_N pin
- bus_sda_oe  out  1  output-enable for the I2C_SDAT pin
- sel_i2c  out  1  1 = I2C owner/idle routing, 0 = SPI routing
- busy  out  1  state is not IDLE
- timeout_flag  out  1  sticky forced-revoke indicator (optional feature)
- timeout_clr  in  1  clears timeout_flag (optional feature)

Behaviour:
- Single clock domain, all logic on rising clk. Reset is synchronous and active-low.
- Reset values:
  - state=IDLE, i2c_gnt=0, spi_gnt=0.
  - bus_sclk=1, bus_cs_n=1, bus_sda_oe=0.
  - sel_i2c=1, busy=0, timeout_flag=0.
  - last_owner=SPI, so I2C wins the first tie.
- States: IDLE, OWN_I2C, OWN_SPI, GUARD.
- IDLE:
  - Only i2c_req high: go to OWN_I2C.
  - Only spi_req high: go to OWN_SPI.
  - Both high: grant the requester that is not last_owner (round-robin).
  - Grant is visible 1 cycle after req is first sampled high.
- OWN_I2C:
  - i2c_gnt=1, sel_i2c=1.
  - bus_sclk <= i2c_scl_in, bus_sda_oe <= i2c_sda_oe_in, bus_cs_n=1.
  - Exit when i2c_req is sampled low: go to GUARD, set last_owner=I2C.
- OWN_SPI:
  - spi_gnt=1, sel_i2c=0.
  - bus_sclk <= spi_sclk_in, bus_cs_n <= spi_cs_n_in, bus_sda_oe <= spi_sdio_oe_in.
  - Exit when spi_req is sampled low: go to GUARD, set last_owner=SPI.
- Bus pin outputs are registered: 1-cycle latency from the owner's inputs to the pins. Non-owner inputs are ignored.
- Grant deassertion happens on the same edge as the GUARD entry.
- GUARD:
  - Both gnt=0. Pins held idle: bus_sclk=1, bus_cs_n=1, bus_sda_oe=0. sel_i2c=1.
  - Counter loads GUARD_CYCLES-1 on entry and decrements; at 0, go to IDLE.
  - Total time from req drop to the next grant is GUARD_CYCLES+2 cycles.
- Requests sampled during GUARD are not lost. Round-robin applies in IDLE.
  - If the releasing owner re-requests together with the other requester, the other requester wins.
- A req pulse shorter than 1 cycle is not captured. Requesters must hold req until gnt is seen.
- Reset mid-ownership: the next edge returns all reset values and the bus is released immediately (no guard).
- Owner req drop coinciding with the other req rise: GUARD is always entered first. No direct owner-to-owner handover exists.
- Counter widths: $clog2(GUARD_CYCLES+1) and $clog2(HOLD_MAX+1). Decrement only, no wrap.

Optional Feature:
- Macro: SENSOR_BUS_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to OWN_* and increments each owned cycle.
  - When it reaches HOLD_MAX-1, ownership is force-revoked: go to GUARD, deassert gnt, set last_owner to the revoked owner, set timeout_flag=1.
  - timeout_flag is sticky until timeout_clr=1. If a set and a clear coincide, the set wins.
  - A revoked owner still holding req re-competes in IDLE after the guard.
- Undefined: no hold limit, timeout_flag tied 0, timeout_clr ignored.

Decomposition:
- Package sensor_bus_pkg:
  - state enum {IDLE, OWN_I2C, OWN_SPI, GUARD}.
  - owner typedef {OWNER_I2C=0, OWNER_SPI=1}.
  - idle pin constants: SCLK_IDLE=1, CS_N_IDLE=1, OE_IDLE=0.
- One sub-module, sensor_bus_pin_mux: registered pin mux selecting owner or idle values from state, with synchronous reset to the idle constants.
- FSM and counters stay in the top module.

Test Plan:
- Reset then i2c_req=1 at cycle 5 -> i2c_gnt=1 at cycle 6. bus_sclk follows i2c_scl_in with 1-cycle lag. bus_cs_n stays 1.
- i2c_req and spi_req both rise at cycle 3 after reset -> i2c_gnt first. Drop i2c_req at cycle 20 -> spi_gnt=1 at cycle 30 (GUARD_CYCLES=8). Pins idle during cycles 21-29.
- While SPI owns the bus, toggle i2c_scl_in and i2c_sda_oe_in -> bus pins track only spi_* inputs.
- Assert reset_n=0 for one cycle during OWN_SPI with spi_cs_n_in=0 -> next edge gives bus_cs_n=1, spi_gnt=0, state IDLE.
- SPI releases and immediately re-requests while i2c_req is held -> i2c_gnt wins after the guard. spi_gnt returns only after I2C releases.
- SENSOR_BUS_TIMEOUT_EN defined, HOLD_MAX=100, i2c_req held -> i2c_gnt drops after 100 owned cycles and timeout_flag=1. timeout_clr=1 -> flag returns to 0 next cycle.
